jk_mod_counter: RTL

- Synchronous modulo-N up/down counter whose state bits are updated with JK flip-flop semantics.
- Each state bit takes J=K=1 to toggle, J=K=0 to hold, J=1/K=0 to set, and J=0/K=1 to clear.
- Sits directly downstream of the team's single-bit JK flip-flop cell and composes a bank of them into a counter.
- Exposes the per-bit J/K drive vectors so a discrete bank of JK cells can be driven in lock-step and cross-checked.

---
 rtl/jk_mod_counter.sv | 94 +++++++++
 1 files changed

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose state bits advance by the JK flip-flop rule.
// The per-bit J/K drives are exported so a discrete bank of JK cells can track it in lock-step.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("jk_mod_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH:0]   cnt_ext, cnt_inc, cnt_dec, load_ext;
    logic [WIDTH-1:0] load_tgt;
    logic             at_max, at_zero;

    // Increment/decrement carry one extra bit so MODULUS == 2**WIDTH still compares correctly.
    always_comb begin
        cnt_ext  = {1'b0, count_q};
        cnt_inc  = cnt_ext + 1'b1;
        cnt_dec  = cnt_ext - 1'b1;
        load_ext = {1'b0, load_val};
        at_max   = (cnt_inc == MOD_EXT);
        at_zero  = cnt_dec[WIDTH];
        load_tgt = (load_ext < MOD_EXT) ? load_val : MAX_VAL;
    end

    always_comb begin
        j_vec = '0;
        k_vec = '0;
        tc_d  = 1'b0;
        if (load) begin
            j_vec = load_tgt;
            k_vec = ~load_tgt;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    k_vec = count_q;
                    tc_d  = 1'b1;
                end else begin
                    j_vec = count_q ^ cnt_inc[WIDTH-1:0];
                    k_vec = count_q ^ cnt_inc[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    j_vec = MAX_VAL;
                    tc_d  = 1'b1;
                end else begin
                    j_vec = count_q ^ cnt_dec[WIDTH-1:0];
                    k_vec = count_q ^ cnt_dec[WIDTH-1:0];
                end
            end
        end
    end

    // Next state is literally the JK characteristic equation, so the exported drives cannot diverge.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_d[i] = (j_vec[i] & ~count_q[i]) | (~k_vec[i] & count_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule
